// File: rtl/aes_pkg.sv
// Shared AES constants and the InvSubBytes engine state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // A counter never collapses to zero bits, even when one beat covers the block.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/inv_substitution_box.sv
// Registered AES inverse S-box: one byte in, its inverse substitution one cycle later.
module inv_substitution_box (
    input  logic       clk,
    input  logic [7:0] A,
    output logic [7:0] C
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // No reset: the output is only consumed behind the engine's write-enable.
    always_ff @(posedge clk) begin
        C <= INV_SBOX[A];
    end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// InvSubBytes engine: streams the 16 state bytes through LANES registered inverse S-boxes per cycle.
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] state_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLOCK_BITS-1:0] state_out,
    output logic                      busy
);

    localparam int             BEATS     = AES_BLOCK_BYTES / LANES;
    localparam int             CW        = cnt_width(BEATS);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);

    aes_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wr_idx_q, wr_idx_d;
    logic          wr_en_q, wr_en_d;

    // Byte 0 sits at index 0, which is the most significant byte of the block.
    logic [0:AES_BLOCK_BYTES-1][7:0] in_q, in_d;
    logic [0:AES_BLOCK_BYTES-1][7:0] out_q, out_d;

    logic [7:0] lane_a [LANES];
    logic [7:0] lane_c [LANES];

    function automatic logic [3:0] byte_idx(input logic [CW-1:0] grp, input int lane);
        return 4'(int'(grp) * LANES + lane);
    endfunction

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_a[gi] = in_q[byte_idx(cnt_q, gi)];

        inv_substitution_box u_sbox (
            .clk (clk),
            .A   (lane_a[gi]),
            .C   (lane_c[gi])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_d      = in_q;
        out_d     = out_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    in_d    = state_in;
                    cnt_d   = '0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                wr_en_d = 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The S-box outputs now belong to the group issued one cycle ago.
        if (wr_en_q) begin
            for (int j = 0; j < LANES; j++) begin
                out_d[byte_idx(wr_idx_q, j)] = lane_c[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            wr_en_q  <= 1'b0;
            in_q     <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_idx_q <= wr_idx_d;
            wr_en_q  <= wr_en_d;
            in_q     <= in_d;
            out_q    <= out_d;
        end
    end

    assign state_out = out_q;

endmodule
